// File: rtl/decoder_select_scheduler_pkg.sv
// Shared types and constants for the decoder select scheduler.
// Combinational helpers only; no state lives here.
// No flow control; consumed by the scheduler and its pick sub-module.
package decoder_select_scheduler_pkg;

  // Scheduler phases: address setup, enable hold, address-hold recovery.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_GRANT   = 2'd2,
    ST_RECOVER = 2'd3
  } state_e;

  // Enable pins ordered {enable1c, enable1g_bar, enable2c_bar, enable2g_bar}.
  localparam logic [3:0] ENABLE_IDLE = 4'b0111;
  localparam logic [3:0] ENABLE_BLK0 = 4'b1011;
  localparam logic [3:0] ENABLE_BLK1 = 4'b0100;

  // Requester index split into decoder block and decoder address.
  typedef struct packed {
    logic       blk;
    logic [7:0] addr;
  } split_t;

  function automatic split_t split_index(input int unsigned idx, input int unsigned width_out);
    split_t s;
    s.blk  = 1'(idx / width_out);
    s.addr = 8'(idx % width_out);
    return s;
  endfunction

endpackage

// File: rtl/decoder_select_scheduler_if.sv
// Requester/decoder-side bundle of the decoder select scheduler.
// Pure wiring; timing is set by the scheduler driving it.
// Requests are levels held until served; no ready/credit return path.
interface decoder_select_scheduler_if #(
  parameter int WIDTH_OUT = 4,
  parameter int BLOCKS    = 2,
  parameter int WIDTH_IN  = $clog2(WIDTH_OUT)
);
  logic [BLOCKS*WIDTH_OUT-1:0] request;
  logic [WIDTH_IN-1:0]         a;
  logic                        enable1c;
  logic                        enable1g_bar;
  logic                        enable2c_bar;
  logic                        enable2g_bar;
  logic [BLOCKS*WIDTH_OUT-1:0] grant;
  logic                        busy;

  modport master (
    input  request,
    output a, enable1c, enable1g_bar, enable2c_bar, enable2g_bar, grant, busy
  );

  modport slave (
    output request,
    input  a, enable1c, enable1g_bar, enable2c_bar, enable2g_bar, grant, busy
  );
endinterface

// File: rtl/decoder_select_scheduler_round_robin_pick.sv
// Round-robin winner search: first set request at or above ptr, wrapping.
// Zero latency, purely combinational.
// No backpressure; any_vld low means nothing to grant.
module round_robin_pick #(
  parameter int N  = 8,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  request,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] winner,
  output logic          any_vld
);

  logic [PW-1:0] cand;

  // Scan from the farthest candidate down so the nearest one to ptr lands last.
  // N is a power of two, so the PW-bit add wraps modulo N for free.
  always_comb begin
    cand    = '0;
    winner  = '0;
    any_vld = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = ptr + PW'(i);
      if (request[cand]) begin
        winner  = cand;
        any_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/decoder_select_scheduler.sv
// Round-robin scheduler sharing a dual 2-to-4 decoder (inverted outputs); macro ARBITER_TIMEOUT_EN adds a hold limit.
// Latency: request seen in IDLE -> address after 1 edge, enables/grant after 2; release -> 1 recover cycle.
// Backpressure: losers keep their request level until granted; holders are never pre-empted except by timeout.
module decoder_select_scheduler
  import decoder_select_scheduler_pkg::*;
#(
  parameter int WIDTH_OUT  = 4,
  parameter int WIDTH_IN   = $clog2(WIDTH_OUT),
  parameter int BLOCKS     = 2,
  parameter int HOLD_MAX   = 15,
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input logic                        core_clk,
  input logic                        clear,
  decoder_select_scheduler_if.master bus
);

  localparam int N  = BLOCKS * WIDTH_OUT;
  localparam int PW = $clog2(N);

  // Pin delays are a board-level annotation; the registered outputs drive the
  // pins directly here. This block only holds the legal-range guard.
  if (HOLD_MAX < 1 || HOLD_MAX > 255 || DELAY_RISE < 0 || DELAY_FALL < 0 || BLOCKS != 2) begin : g_param_out_of_range
  end

  state_e              state_q, state_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [PW-1:0]       win_q, win_d;
  logic [WIDTH_IN-1:0] a_q, a_d;
  logic [3:0]          en_q, en_d;
  logic [N-1:0]        grant_q, grant_d;
  logic                busy_q, busy_d;
  logic [PW-1:0]       pick_idx;
  logic                pick_vld;
  split_t              win_split;
`ifdef ARBITER_TIMEOUT_EN
  logic [7:0]          cnt_q, cnt_d;
`endif

  round_robin_pick #(.N(N), .PW(PW)) u_pick (
    .request (bus.request),
    .ptr     (ptr_q),
    .winner  (pick_idx),
    .any_vld (pick_vld)
  );

  // Phase sequencing and arbitration; the pointer moves past the winner at selection time.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
`ifdef ARBITER_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          win_d   = pick_idx;
          ptr_d   = pick_idx + PW'(1);
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_d = ST_GRANT;
`ifdef ARBITER_TIMEOUT_EN
        cnt_d   = 8'd0;
`endif
      end
      ST_GRANT: begin
`ifdef ARBITER_TIMEOUT_EN
        cnt_d = cnt_q + 8'd1;
        if (!bus.request[win_q] || cnt_d == 8'(HOLD_MAX)) begin
          state_d = ST_RECOVER;
        end
`else
        if (!bus.request[win_q]) begin
          state_d = ST_RECOVER;
        end
`endif
      end
      ST_RECOVER: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output values for the upcoming phase, so every pin comes straight from a flop.
  always_comb begin
    win_split = split_index(32'(win_d), 32'(WIDTH_OUT));
    a_d       = a_q;
    en_d      = ENABLE_IDLE;
    grant_d   = '0;
    busy_d    = (state_d != ST_IDLE);
    if (state_d == ST_SETUP) begin
      a_d = WIDTH_IN'(win_split.addr);
    end
    if (state_d == ST_GRANT) begin
      en_d    = win_split.blk ? ENABLE_BLK1 : ENABLE_BLK0;
      grant_d = N'(1) << win_d;
    end
  end

  // State and output registers; clear drops enables at once with no recover cycle.
  always_ff @(posedge core_clk) begin
    if (clear) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      a_q     <= '0;
      en_q    <= ENABLE_IDLE;
      grant_q <= '0;
      busy_q  <= 1'b0;
`ifdef ARBITER_TIMEOUT_EN
      cnt_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      a_q     <= a_d;
      en_q    <= en_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
`ifdef ARBITER_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus.a            = a_q;
  assign bus.enable1c     = en_q[3];
  assign bus.enable1g_bar = en_q[2];
  assign bus.enable2c_bar = en_q[1];
  assign bus.enable2g_bar = en_q[0];
  assign bus.grant        = grant_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_decoder_select_scheduler.sv
// Self-checking bench for decoder_select_scheduler (HOLD_MAX=3; ARBITER_TIMEOUT_EN optional).
// A phase-level reference model is compared every cycle; directed literals pin the model.
// Requests are driven on the falling edge, outputs sampled on the falling edge.
module tb_decoder_select_scheduler;

  localparam int WO   = 4;
  localparam int BL   = 2;
  localparam int N    = WO * BL;
  localparam int HOLD = 3;

  localparam int P_IDLE    = 0;
  localparam int P_SETUP   = 1;
  localparam int P_GRANT   = 2;
  localparam int P_RECOVER = 3;

  logic clk;
  logic clear;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   chk_on   = 1'b0;

  decoder_select_scheduler_if #(.WIDTH_OUT(WO), .BLOCKS(BL)) bus();

  decoder_select_scheduler #(
    .WIDTH_OUT (WO),
    .BLOCKS    (BL),
    .HOLD_MAX  (HOLD)
  ) dut (
    .core_clk (clk),
    .clear    (clear),
    .bus      (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] pins();
    return {bus.enable1c, bus.enable1g_bar, bus.enable2c_bar, bus.enable2g_bar};
  endfunction

  function automatic int onehot_idx(input logic [7:0] v);
    int r;
    r = -1;
    for (int k = 0; k < N; k++) if (v[k]) r = k;
    return r;
  endfunction

  // ---------------- reference model (phase level) ----------------
  int m_phase, m_ptr, m_win, m_a, m_held, m_found;
  logic [3:0] exp_en;
  logic [7:0] exp_grant;

  always @(posedge clk) begin
    if (clear) begin
      m_phase = P_IDLE; m_ptr = 0; m_win = 0; m_a = 0; m_held = 0;
    end else begin
      case (m_phase)
        P_IDLE: begin
          m_found = -1;
          for (int k = 0; k < N; k++)
            if (m_found < 0 && bus.request[(m_ptr + k) % N]) m_found = (m_ptr + k) % N;
          if (m_found >= 0) begin
            m_win = m_found; m_ptr = (m_found + 1) % N; m_a = m_found % WO; m_phase = P_SETUP;
          end
        end
        P_SETUP: begin m_phase = P_GRANT; m_held = 0; end
        P_GRANT: begin
          m_held++;
          if (!bus.request[m_win]) m_phase = P_RECOVER;
`ifdef ARBITER_TIMEOUT_EN
          else if (m_held == HOLD) m_phase = P_RECOVER;
`endif
        end
        default: m_phase = P_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      exp_en    = 4'b0111;
      exp_grant = 8'h00;
      if (m_phase == P_GRANT) begin
        exp_en    = (m_win / WO == 0) ? 4'b1011 : 4'b0100;
        exp_grant = 8'(1) << m_win;
      end
      check("model_a",      32'(bus.a),     32'(m_a));
      check("model_enable", 32'(pins()),    32'(exp_en));
      check("model_grant",  32'(bus.grant), 32'(exp_grant));
      check("model_busy",   32'(bus.busy),  32'(m_phase != P_IDLE));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_grant(output logic [7:0] got);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.grant == 8'h00 && n < 30);
    got = bus.grant;
    if (got == 8'h00) begin
      n_checks++; n_fail++;
      $display("FAIL grant_wait: grant still 0 after 30 cycles, required a grant");
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.busy && n < 30);
    if (bus.busy) begin
      n_checks++; n_fail++;
      $display("FAIL idle_wait: busy still 1 after 30 cycles, required 0");
    end
  endtask

  task automatic do_grant(input logic [7:0] req, input int hold, output logic [7:0] got);
    bus.request = req;
    wait_grant(got);
    repeat (hold - 1) @(negedge clk);
    bus.request = bus.request & ~got;
    wait_idle();
  endtask

  // ---------------- directed sequence ----------------
  logic [7:0] got, last;
  int held_c, ngr, idx_g, hold_len;
  bit stay;
  int order[9];
  int exp_order[9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};

  initial begin
    clear = 1'b1;
    bus.request = 8'hFF;
    @(posedge clk);
    #1 chk_on = 1'b1;

    // Reset held two cycles with every request high.
    @(negedge clk);
    @(negedge clk);
    check("rst_a", 32'(bus.a), 32'h0);
    check("rst_enable", 32'(pins()), 32'h7);
    check("rst_grant", 32'(bus.grant), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);

    // Single requester in block 1.
    clear = 1'b0;
    bus.request = 8'h20;
    @(negedge clk);
    check("setup_a", 32'(bus.a), 32'h1);
    check("setup_busy", 32'(bus.busy), 32'h1);
    check("setup_enable", 32'(pins()), 32'h7);
    @(negedge clk);
    check("grant_enable_blk1", 32'(pins()), 32'h4);
    check("grant_vec", 32'(bus.grant), 32'h20);
    bus.request = 8'h00;
    @(negedge clk);
    check("recover_enable", 32'(pins()), 32'h7);
    check("recover_busy", 32'(bus.busy), 32'h1);
    check("recover_a_held", 32'(bus.a), 32'h1);
    @(negedge clk);
    check("idle_busy", 32'(bus.busy), 32'h0);

    // Full request set, each holder releases after two grant cycles.
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    bus.request = 8'hFF;
    last = 8'h00; held_c = 0; ngr = 0;
    for (int c = 0; c < 300 && ngr < 9; c++) begin
      @(negedge clk);
      if (bus.grant != 8'h00) begin
        if (bus.grant != last) begin
          idx_g = onehot_idx(bus.grant);
          order[ngr] = idx_g;
          ngr++;
          held_c = 1;
          last = bus.grant;
          check("rr_block_enable", 32'(pins()), (idx_g < 4) ? 32'hB : 32'h4);
        end else begin
          held_c++;
        end
        if (held_c == 2 || ngr == 9) bus.request = bus.request & ~bus.grant;
      end else begin
        last = 8'h00;
        if (bus.busy) bus.request = 8'hFF;
      end
    end
    if (ngr != 9) begin
      n_checks++; n_fail++;
      $display("FAIL rr_count: saw %0d grants, required 9", ngr);
    end else begin
      for (int k = 0; k < 9; k++) check("rr_order", 32'(order[k]), 32'(exp_order[k]));
    end
    bus.request = 8'h00;
    wait_idle();

    // Wrap-around: grant 6 leaves the pointer at 7.
    do_grant(8'h40, 1, got);
    check("wrap_pre", 32'(got), 32'h40);
    do_grant(8'h81, 1, got);
    check("wrap_first", 32'(got), 32'h80);
    do_grant(8'h01, 1, got);
    check("wrap_second", 32'(got), 32'h01);

    // Persistent holder on index 2 with index 3 waiting.
    bus.request = 8'h0C;
    wait_grant(got);
    check("hold_first", 32'(got), 32'h04);
`ifdef ARBITER_TIMEOUT_EN
    hold_len = 1; stay = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (stay) begin
        @(negedge clk);
        if (bus.grant == 8'h04) hold_len++;
        else stay = 1'b0;
      end
    end
    check("timeout_len", 32'(hold_len), 32'h3);
    check("timeout_recover_busy", 32'(bus.busy), 32'h1);
    wait_grant(got);
    check("timeout_requeue", 32'(got), 32'h08);
`else
    repeat (10) @(negedge clk);
    check("no_timeout_hold", 32'(bus.grant), 32'h04);
`endif
    bus.request = 8'h00;
    wait_idle();

    // Clear during the second grant cycle of index 1.
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    bus.request = 8'h02;
    wait_grant(got);
    check("clr_first", 32'(got), 32'h02);
    @(negedge clk);
    check("clr_second_cycle", 32'(bus.grant), 32'h02);
    clear = 1'b1;
    @(negedge clk);
    check("clr_enable", 32'(pins()), 32'h7);
    check("clr_grant", 32'(bus.grant), 32'h0);
    check("clr_busy", 32'(bus.busy), 32'h0);
    check("clr_a", 32'(bus.a), 32'h0);
    clear = 1'b0;
    bus.request = 8'h05;
    wait_grant(got);
    check("clr_ptr_zero", 32'(got), 32'h01);
    bus.request = 8'h00;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
